pad_input: RTL and testbench

- Input-side counterpart of the step display path: conditions the four raw dance-pad switches into clean, beat-aligned hit information for the scoring block.
- Synchronises and debounces each pad, then emits a one-cycle press pulse per pad.
- Accumulates presses within the current beat window; on every stepEn beat pulse, hands the window's hits to scoring as a snapshot plus valid strobe.
- Sits between the board pad pins and scoring, clocked by clk alongside stepShiftRegister.

---
 rtl/ddr_pkg.sv | 13 +
 rtl/pad_input_if.sv | 24 ++
 rtl/pad_debouncer.sv | 62 ++++++
 rtl/pad_input.sv | 54 +++++
 tb/tb_pad_input.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_pkg.sv
// Shared dance-pad types and pad index constants.
// Used by pad input, scoring and the step display path.
package ddr_pkg;

   localparam int N_PADS    = 4;
   localparam int PAD_LEFT  = 0;
   localparam int PAD_DOWN  = 1;
   localparam int PAD_UP    = 2;
   localparam int PAD_RIGHT = 3;

   typedef logic [N_PADS-1:0] pad_vec_t;

endpackage

// File: rtl/pad_input_if.sv
// Pad pins, beat pulse and conditioned hit outputs of pad_input.
// master = board/testbench side, slave = pad_input.
interface pad_input_if;
   import ddr_pkg::*;

   pad_vec_t padRaw;
   logic     stepEn;
   pad_vec_t pressed;
   pad_vec_t newPress;
   pad_vec_t button;
   pad_vec_t beatHits;
   logic     beatValid;

   modport master (
      output padRaw, stepEn,
      input  pressed, newPress, button, beatHits, beatValid
   );

   modport slave (
      input  padRaw, stepEn,
      output pressed, newPress, button, beatHits, beatValid
   );

endinterface

// File: rtl/pad_debouncer.sv
// One pad: 2-flop synchroniser, stability counter, stable level
// and a one-cycle pulse the cycle after a debounced press.
module pad_debouncer #(
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic clk,
   input  logic reset,
   input  logic rawN,
   output logic pressed,
   output logic newPress
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Flops carry the raw active-low level so reset means released.
   logic             sync1;
   logic             sync2;
   logic             syncLvl;
   logic             stable;
   logic             stableD;
   logic [CNT_W-1:0] count;

   assign syncLvl = ~sync2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= rawN;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable <= 1'b0;
         count  <= '0;
      end else if (syncLvl == stable) begin
         count  <= '0;
      end else if (count == CNT_MAX) begin
         stable <= syncLvl;
         count  <= '0;
      end else begin
         count  <= count + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stableD  <= 1'b0;
         newPress <= 1'b0;
      end else begin
         stableD  <= stable;
         newPress <= stable & ~stableD;
      end
   end

   assign pressed = stable;

endmodule

// File: rtl/pad_input.sv
// Conditions raw pad switches into debounced levels, press pulses
// and per-beat hit snapshots for scoring.
module pad_input
   import ddr_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input logic        clk,
   input logic        reset,
   pad_input_if.slave pads
);

   pad_vec_t pressedV;
   pad_vec_t newPressV;
   pad_vec_t buttonQ;
   pad_vec_t beatHitsQ;
   logic     beatValidQ;

   for (genvar i = 0; i < N_PADS; i++) begin : g_pad
      pad_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk     (clk),
         .reset   (reset),
         .rawN    (pads.padRaw[i]),
         .pressed (pressedV[i]),
         .newPress(newPressV[i])
      );
   end

   // A press landing on the beat closes with the old window.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buttonQ    <= '0;
         beatHitsQ  <= '0;
         beatValidQ <= 1'b0;
      end else begin
         beatValidQ <= pads.stepEn;
         if (pads.stepEn) begin
            beatHitsQ <= buttonQ | newPressV;
            buttonQ   <= '0;
         end else begin
            buttonQ   <= buttonQ | newPressV;
         end
      end
   end

   assign pads.pressed   = pressedV;
   assign pads.newPress  = newPressV;
   assign pads.button    = buttonQ;
   assign pads.beatHits  = beatHitsQ;
   assign pads.beatValid = beatValidQ;

endmodule

// File: tb/tb_pad_input.sv
// Directed bench for pad_input with an 8-cycle debounce.
// Inputs change and outputs are read 1 time unit after posedge.
module tb_pad_input;
   import ddr_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   passed = 0;
   int   total = 0;

   pad_input_if bus ();

   pad_input #(
      .DEBOUNCE_CYCLES(8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .pads (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bus.padRaw = '1;
      bus.stepEn = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.padRaw = '1;
      bus.stepEn = 1'b0;
      #2;
      total++;
      if (bus.pressed !== 4'b0000)
         $display("FAIL reset_pressed got %b want 0000", bus.pressed);
      else passed++;
      total++;
      if (bus.newPress !== 4'b0000)
         $display("FAIL reset_newPress got %b want 0000", bus.newPress);
      else passed++;
      total++;
      if (bus.button !== 4'b0000)
         $display("FAIL reset_button got %b want 0000", bus.button);
      else passed++;
      total++;
      if (bus.beatHits !== 4'b0000)
         $display("FAIL reset_beatHits got %b want 0000", bus.beatHits);
      else passed++;
      total++;
      if (bus.beatValid !== 1'b0)
         $display("FAIL reset_beatValid got %b want 0", bus.beatValid);
      else passed++;
   endtask

   task automatic test_clean_press();
      pad_vec_t ep, en, eb;
      do_reset();
      bus.padRaw[PAD_LEFT] = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         step();
         ep = (n >= 10) ? 4'b0001 : 4'b0000;
         en = (n == 11) ? 4'b0001 : 4'b0000;
         eb = (n >= 12) ? 4'b0001 : 4'b0000;
         total++;
         if (bus.pressed !== ep)
            $display("FAIL clean_pressed n=%0d got %b want %b", n, bus.pressed, ep);
         else passed++;
         total++;
         if (bus.newPress !== en)
            $display("FAIL clean_newPress n=%0d got %b want %b", n, bus.newPress, en);
         else passed++;
         total++;
         if (bus.button !== eb)
            $display("FAIL clean_button n=%0d got %b want %b", n, bus.button, eb);
         else passed++;
      end
   endtask

   task automatic test_bounce();
      pad_vec_t ep, en;
      do_reset();
      for (int seg = 0; seg < 10; seg++) begin
         bus.padRaw[PAD_UP] = (seg % 2 == 1);
         repeat (3) begin
            step();
            total++;
            if (bus.newPress !== 4'b0000 || bus.pressed !== 4'b0000)
               $display("FAIL bounce_quiet seg=%0d got p=%b n=%b want 0000",
                        seg, bus.pressed, bus.newPress);
            else passed++;
         end
      end
      bus.padRaw[PAD_UP] = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         step();
         ep = (n >= 10) ? 4'b0100 : 4'b0000;
         en = (n == 11) ? 4'b0100 : 4'b0000;
         total++;
         if (bus.pressed !== ep)
            $display("FAIL bounce_pressed n=%0d got %b want %b", n, bus.pressed, ep);
         else passed++;
         total++;
         if (bus.newPress !== en)
            $display("FAIL bounce_newPress n=%0d got %b want %b", n, bus.newPress, en);
         else passed++;
      end
      bus.padRaw[PAD_UP] = 1'b1;
      repeat (5) step();
      bus.padRaw[PAD_UP] = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         step();
         total++;
         if (bus.pressed !== 4'b0100 || bus.newPress !== 4'b0000)
            $display("FAIL glitch_hold n=%0d got p=%b n=%b want p=0100 n=0000",
                     n, bus.pressed, bus.newPress);
         else passed++;
      end
   endtask

   task automatic test_beat_snapshot();
      do_reset();
      bus.padRaw = 4'b0101;
      repeat (12) step();
      total++;
      if (bus.button !== 4'b1010 || bus.beatValid !== 1'b0)
         $display("FAIL snap_pre got b=%b v=%b want b=1010 v=0",
                  bus.button, bus.beatValid);
      else passed++;
      bus.stepEn = 1'b1;
      step();
      bus.stepEn = 1'b0;
      total++;
      if (bus.beatValid !== 1'b1 || bus.beatHits !== 4'b1010 || bus.button !== 4'b0000)
         $display("FAIL snap_beat got v=%b h=%b b=%b want v=1 h=1010 b=0000",
                  bus.beatValid, bus.beatHits, bus.button);
      else passed++;
      step();
      total++;
      if (bus.beatValid !== 1'b0 || bus.beatHits !== 4'b1010)
         $display("FAIL snap_after got v=%b h=%b want v=0 h=1010",
                  bus.beatValid, bus.beatHits);
      else passed++;
   endtask

   task automatic test_coincident();
      do_reset();
      bus.padRaw[PAD_LEFT] = 1'b0;
      repeat (11) step();
      total++;
      if (bus.newPress !== 4'b0001)
         $display("FAIL coin_newPress got %b want 0001", bus.newPress);
      else passed++;
      bus.stepEn = 1'b1;
      step();
      bus.stepEn = 1'b0;
      total++;
      if (bus.beatValid !== 1'b1 || bus.beatHits !== 4'b0001 || bus.button !== 4'b0000)
         $display("FAIL coin_beat got v=%b h=%b b=%b want v=1 h=0001 b=0000",
                  bus.beatValid, bus.beatHits, bus.button);
      else passed++;
      repeat (3) step();
      bus.stepEn = 1'b1;
      step();
      bus.stepEn = 1'b0;
      total++;
      if (bus.beatValid !== 1'b1 || bus.beatHits !== 4'b0000)
         $display("FAIL coin_next got v=%b h=%b want v=1 h=0000",
                  bus.beatValid, bus.beatHits);
      else passed++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus.padRaw[PAD_LEFT] = 1'b0;
      repeat (10) step();
      bus.stepEn = 1'b1;
      step();
      total++;
      if (bus.beatValid !== 1'b1 || bus.beatHits !== 4'b0000)
         $display("FAIL b2b_first got v=%b h=%b want v=1 h=0000",
                  bus.beatValid, bus.beatHits);
      else passed++;
      step();
      bus.stepEn = 1'b0;
      total++;
      if (bus.beatValid !== 1'b1 || bus.beatHits !== 4'b0001 || bus.button !== 4'b0000)
         $display("FAIL b2b_second got v=%b h=%b b=%b want v=1 h=0001 b=0000",
                  bus.beatValid, bus.beatHits, bus.button);
      else passed++;
      step();
      total++;
      if (bus.beatValid !== 1'b0 || bus.button !== 4'b0000)
         $display("FAIL b2b_after got v=%b b=%b want v=0 b=0000",
                  bus.beatValid, bus.button);
      else passed++;
   endtask

   task automatic test_held();
      pad_vec_t eh;
      do_reset();
      bus.padRaw = 4'b1101;
      repeat (13) step();
      for (int b = 0; b < 3; b++) begin
         bus.stepEn = 1'b1;
         step();
         bus.stepEn = 1'b0;
         eh = (b == 0) ? 4'b0010 : 4'b0000;
         total++;
         if (bus.beatValid !== 1'b1 || bus.beatHits !== eh)
            $display("FAIL held_beat b=%0d got v=%b h=%b want v=1 h=%b",
                     b, bus.beatValid, bus.beatHits, eh);
         else passed++;
         total++;
         if (bus.pressed !== 4'b0010)
            $display("FAIL held_pressed b=%0d got %b want 0010", b, bus.pressed);
         else passed++;
         repeat (4) step();
      end
   endtask

   task automatic test_async_reset();
      pad_vec_t ep;
      do_reset();
      bus.padRaw = 4'b1001;
      repeat (13) step();
      total++;
      if (bus.button !== 4'b0110 || bus.pressed !== 4'b0110)
         $display("FAIL ares_pre got b=%b p=%b want b=0110 p=0110",
                  bus.button, bus.pressed);
      else passed++;
      bus.padRaw = 4'b1000;
      repeat (7) step();
      #2;
      reset = 1'b0;
      #1;
      total++;
      if (bus.pressed !== 4'b0000 || bus.button !== 4'b0000 || bus.newPress !== 4'b0000
          || bus.beatHits !== 4'b0000 || bus.beatValid !== 1'b0)
         $display("FAIL ares_now got p=%b n=%b b=%b h=%b v=%b want all 0",
                  bus.pressed, bus.newPress, bus.button, bus.beatHits, bus.beatValid);
      else passed++;
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         step();
         ep = (n >= 10) ? 4'b0111 : 4'b0000;
         total++;
         if (bus.pressed !== ep)
            $display("FAIL ares_rise n=%0d got %b want %b", n, bus.pressed, ep);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_beat_snapshot();
      test_coincident();
      test_back_to_back();
      test_held();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
